// File: rtl/neuron_layer_driver.sv
// Layer sequencer for a single serial neuron MAC: owns the weight/bias table,
// issues one operation per neuron over the in_valid/in_ready handshake and assembles the results.
module neuron_layer_driver #(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 8,
    parameter int X_W         = 8,
    parameter int W_W         = 8,
    parameter int B_W         = 32,
    parameter int OUT_W       = 16,
    localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [IDX_W-1:0]             cfg_addr,
    input  logic [NUM_INPUTS*W_W-1:0]    cfg_w_flat,
    input  logic [B_W-1:0]               cfg_bias,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NUM_INPUTS*X_W-1:0]    req_x_flat,
    output logic                         nrn_in_valid,
    input  logic                         nrn_in_ready,
    output logic [B_W-1:0]               nrn_bias,
    output logic [NUM_INPUTS*X_W-1:0]    nrn_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]    nrn_w_flat,
    input  logic                         nrn_out_valid,
    input  logic [OUT_W-1:0]             nrn_out_data,
    output logic                         res_valid,
    output logic [NUM_NEURONS*OUT_W-1:0] res_y_flat,
    output logic                         busy
);

    localparam int XV_W = NUM_INPUTS * X_W;
    localparam int WV_W = NUM_INPUTS * W_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [XV_W-1:0]  x_lat;
    logic [WV_W-1:0]  w_tab  [NUM_NEURONS];
    logic [B_W-1:0]   b_tab  [NUM_NEURONS];
    logic [OUT_W-1:0] y_slot [NUM_NEURONS];
    logic             cfg_hit;

    // Table is writable only while idle; out-of-range addresses are dropped.
    assign cfg_hit = cfg_we && (state == ST_IDLE) && (32'(cfg_addr) < 32'(NUM_NEURONS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                w_tab[i] <= '0;
                b_tab[i] <= '0;
            end
        end else if (cfg_hit) begin
            w_tab[cfg_addr] <= cfg_w_flat;
            b_tab[cfg_addr] <= cfg_bias;
        end
    end

    assign nrn_w_flat = w_tab[idx];
    assign nrn_bias   = b_tab[idx];
    assign nrn_x_flat = x_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            x_lat        <= '0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            nrn_in_valid <= 1'b0;
            res_valid    <= 1'b0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                y_slot[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        x_lat        <= req_x_flat;
                        idx          <= '0;
                        state        <= ST_ISSUE;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        nrn_in_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (nrn_in_ready) begin
                        nrn_in_valid <= 1'b0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (nrn_out_valid) begin
                        y_slot[idx] <= nrn_out_data;
                        if (idx == LAST_IDX) begin
                            state     <= ST_DONE;
                            res_valid <= 1'b1;
                        end else begin
                            idx          <= idx + 1'b1;
                            state        <= ST_ISSUE;
                            nrn_in_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    res_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        res_y_flat = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            res_y_flat[i*OUT_W +: OUT_W] = y_slot[i];
        end
    end

endmodule

// File: tb/tb_neuron_layer_driver.sv
// Randomized bench for neuron_layer_driver with a behavioural neuron stand-in
// and a table-level reference model of the layer result.
module tb_neuron_layer_driver;

    localparam int NN = 5;
    localparam int NI = 8;
    localparam int XW = 8;
    localparam int WW = 8;
    localparam int BW = 32;
    localparam int OW = 16;
    localparam int IW = 3;
    localparam int XV = NI * XW;
    localparam int WV = NI * WW;
    localparam int YW = NN * OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [WV-1:0] cfg_w_flat;
    logic [BW-1:0] cfg_bias;
    logic          req_valid;
    logic          req_ready;
    logic [XV-1:0] req_x_flat;
    logic          nrn_in_valid;
    logic          nrn_in_ready = 1'b0;
    logic [BW-1:0] nrn_bias;
    logic [XV-1:0] nrn_x_flat;
    logic [WV-1:0] nrn_w_flat;
    logic          nrn_out_valid = 1'b0;
    logic [OW-1:0] nrn_out_data = '0;
    logic          res_valid;
    logic [YW-1:0] res_y_flat;
    logic          busy;

    neuron_layer_driver #(
        .NUM_NEURONS(NN), .NUM_INPUTS(NI), .X_W(XW), .W_W(WW), .B_W(BW), .OUT_W(OW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w_flat(cfg_w_flat), .cfg_bias(cfg_bias),
        .req_valid(req_valid), .req_ready(req_ready), .req_x_flat(req_x_flat),
        .nrn_in_valid(nrn_in_valid), .nrn_in_ready(nrn_in_ready), .nrn_bias(nrn_bias),
        .nrn_x_flat(nrn_x_flat), .nrn_w_flat(nrn_w_flat),
        .nrn_out_valid(nrn_out_valid), .nrn_out_data(nrn_out_data),
        .res_valid(res_valid), .res_y_flat(res_y_flat), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference table and neuron arithmetic: signed dot product plus bias, ReLU, truncate.
    logic [WV-1:0] ref_w [NN];
    logic [BW-1:0] ref_b [NN];
    logic [YW-1:0] prev_y = '0;

    function automatic logic [OW-1:0] neuron_ref(input logic [XV-1:0] x, input logic [WV-1:0] w,
                                                 input logic [BW-1:0] b);
        longint acc;
        acc = longint'($signed(b));
        for (int i = 0; i < NI; i++) begin
            logic signed [XW-1:0] xs;
            logic signed [WW-1:0] ws;
            xs = x[i*XW +: XW];
            ws = w[i*WW +: WW];
            acc += longint'(xs) * longint'(ws);
        end
        if (acc < 0) acc = 0;
        return acc[OW-1:0];
    endfunction

    function automatic logic [YW-1:0] layer_ref(input logic [XV-1:0] x);
        logic [YW-1:0] y;
        y = '0;
        for (int k = 0; k < NN; k++) y[k*OW +: OW] = neuron_ref(x, ref_w[k], ref_b[k]);
        return y;
    endfunction

    function automatic logic [WV-1:0] rand_row();
        logic [WV-1:0] r;
        for (int i = 0; i < NI; i++) r[i*WW +: WW] = WW'($urandom);
        return r;
    endfunction

    function automatic logic [XV-1:0] rand_x();
        logic [XV-1:0] r;
        for (int i = 0; i < NI; i++) r[i*XW +: XW] = XW'($urandom);
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_bias();
        return BW'($urandom_range(0, 4000)) - 32'd2000;
    endfunction

    // Neuron stand-in state
    int  stall_cfg = 0;
    int  lat_cfg = 1;
    int  stall_cnt = 0;
    int  lat_cnt = 0;
    bit  hs_pend = 0;
    bit  just_hs = 0;
    bit  spur_issue_arm = 0;
    bit  spur_idle_req = 0;
    bit  snap_vld = 0;
    int  stable_err = 0;
    int  rv_count = 0;
    logic [OW-1:0] m_result = '0;
    logic [WV+BW+XV-1:0] snap;
    logic [WV+BW-1:0] hs_rec [$];
    logic [XV-1:0] hs_x [$];

    // Observe the interface just before each rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            snap_vld = 0;
            hs_pend  = 0;
        end else if (nrn_in_valid) begin
            if (!snap_vld) begin
                snap = {nrn_w_flat, nrn_bias, nrn_x_flat};
                snap_vld = 1;
            end else if (snap !== {nrn_w_flat, nrn_bias, nrn_x_flat}) begin
                stable_err++;
            end
            if (nrn_in_ready) begin
                hs_pend = 1;
                hs_rec.push_back({nrn_w_flat, nrn_bias});
                hs_x.push_back(nrn_x_flat);
                m_result = neuron_ref(nrn_x_flat, nrn_w_flat, nrn_bias);
                snap_vld = 0;
            end
        end else if (snap_vld) begin
            stable_err++;
            snap_vld = 0;
        end
        if (res_valid) rv_count++;
    end

    always @(posedge clk) begin
        #1;
        nrn_out_valid = 1'b0;
        just_hs = 0;
        if (!rst_n) begin
            nrn_in_ready = 1'b0;
            lat_cnt = 0;
            stall_cnt = 0;
            hs_pend = 0;
        end else begin
            if (hs_pend) begin
                hs_pend = 0;
                just_hs = 1;
                lat_cnt = lat_cfg;
                stall_cnt = 0;
                nrn_in_ready = 1'b0;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    nrn_out_valid = 1'b1;
                    nrn_out_data  = m_result;
                end
            end
            if (!just_hs && lat_cnt == 0) begin
                if (stall_cfg == 0) begin
                    nrn_in_ready = 1'b1;
                end else if (nrn_in_valid) begin
                    if (stall_cnt < stall_cfg) begin
                        stall_cnt++;
                        nrn_in_ready = 1'b0;
                        if (spur_issue_arm && stall_cnt == 2) begin
                            spur_issue_arm = 0;
                            nrn_out_valid  = 1'b1;
                            nrn_out_data   = 16'h1234;
                        end
                    end else begin
                        nrn_in_ready = 1'b1;
                    end
                end else begin
                    nrn_in_ready = 1'b0;
                end
            end
            if (spur_idle_req && !nrn_out_valid && lat_cnt == 0) begin
                spur_idle_req = 0;
                nrn_out_valid = 1'b1;
                nrn_out_data  = 16'h1234;
            end
        end
    end

    task automatic cfg_write(input int a, input logic [WV-1:0] w, input logic [BW-1:0] b);
        cfg_we = 1'b1;
        cfg_addr = IW'(a);
        cfg_w_flat = w;
        cfg_bias = b;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < NN) begin
            ref_w[a] = w;
            ref_b[a] = b;
        end
    endtask

    task automatic load_random_table();
        for (int k = 0; k < NN; k++) cfg_write(k, rand_row(), rand_bias());
    endtask

    // mode: 0 plain, 1 write while busy, 2 write+request same cycle,
    //       3 reset during WAIT of neuron 2, 4 spurious pulse during ISSUE
    task automatic run_layer(input string name, input logic [XV-1:0] x, input int mode);
        logic [YW-1:0] exp_y;
        int cyc;
        int bad_x;
        hs_rec.delete();
        hs_x.delete();
        stable_err = 0;
        spur_issue_arm = (mode == 4);
        req_x_flat = x;
        req_valid  = 1'b1;
        if (mode == 2) begin
            cfg_we = 1'b1; cfg_addr = '0; cfg_w_flat = '0; cfg_bias = 32'h300;
            ref_w[0] = '0; ref_b[0] = 32'h300;
        end
        exp_y = layer_ref(x);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        cfg_we     = 1'b0;
        req_x_flat = rand_x();
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            if (mode == 3 && hs_rec.size() == 3 && !nrn_in_valid && busy) begin
                #2 rst_n = 1'b0;
                #1;
                check({name, "_rst_req_ready"}, 128'(req_ready), 128'(1));
                check({name, "_rst_busy"}, 128'(busy), 128'(0));
                check({name, "_rst_in_valid"}, 128'(nrn_in_valid), 128'(0));
                check({name, "_rst_res_valid"}, 128'(res_valid), 128'(0));
                check({name, "_rst_y"}, 128'(res_y_flat), 128'(0));
                check({name, "_rst_bias"}, 128'(nrn_bias), 128'(0));
                for (int k = 0; k < NN; k++) begin
                    ref_w[k] = '0;
                    ref_b[k] = '0;
                end
                prev_y = '0;
                repeat (2) @(posedge clk);
                @(negedge clk) rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (mode == 4 && cyc == 3) begin
                check({name, "_spur_y"}, 128'(res_y_flat), 128'(prev_y));
                check({name, "_spur_in_valid"}, 128'(nrn_in_valid), 128'(1));
            end
            if (res_valid) break;
            @(posedge clk); #1;
            cyc++;
            if (mode == 1 && cyc == 2) begin
                cfg_we = 1'b1; cfg_addr = IW'(1); cfg_w_flat = rand_row(); cfg_bias = rand_bias();
            end else begin
                cfg_we = 1'b0;
            end
        end
        cfg_we = 1'b0;
        check({name, "_res_valid"}, 128'(res_valid), 128'(1));
        check({name, "_busy_at_done"}, 128'(busy), 128'(1));
        if (stall_cfg == 0 && (mode == 0 || mode == 2))
            check({name, "_latency"}, 128'(cyc), 128'(NN * (lat_cfg + 2)));
        check({name, "_y"}, 128'(res_y_flat), 128'(exp_y));
        check({name, "_hs_count"}, 128'(hs_rec.size()), 128'(NN));
        for (int k = 0; k < NN && k < hs_rec.size(); k++)
            check($sformatf("%s_hs%0d_row", name, k), 128'(hs_rec[k]), 128'({ref_w[k], ref_b[k]}));
        bad_x = 0;
        foreach (hs_x[i]) if (hs_x[i] !== x) bad_x++;
        check({name, "_x_latched"}, 128'(bad_x), 128'(0));
        check({name, "_stable"}, 128'(stable_err), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_pulse_end"}, 128'(res_valid), 128'(0));
        check({name, "_ready_back"}, 128'(req_ready), 128'(1));
        check({name, "_busy_low"}, 128'(busy), 128'(0));
        prev_y = exp_y;
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        logic [XV-1:0] x;
        logic [WV-1:0] w_one;
        logic [BW-1:0] basic_b [NN];
        logic [OW-1:0] basic_y [NN];

        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_w_flat = '0; cfg_bias = '0;
        req_valid = 1'b0; req_x_flat = '0;
        for (int k = 0; k < NN; k++) begin
            ref_w[k] = '0;
            ref_b[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 128'(req_ready), 128'(1));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_in_valid", 128'(nrn_in_valid), 128'(0));
        check("reset_res_valid", 128'(res_valid), 128'(0));
        check("reset_y", 128'(res_y_flat), 128'(0));
        check("reset_x", 128'(nrn_x_flat), 128'(0));
        check("reset_row", 128'({nrn_w_flat, nrn_bias}), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic layer: weights and inputs 1.0 in Q4.4
        w_one = {NI{8'h10}};
        basic_b = '{32'h0, 32'h100, 32'hFFFFFF00, 32'h200, 32'h300};
        basic_y = '{16'h0800, 16'h0900, 16'h0700, 16'h0A00, 16'h0B00};
        for (int k = 0; k < NN; k++) cfg_write(k, w_one, basic_b[k]);
        stall_cfg = 0; lat_cfg = 1;
        x = {NI{8'h10}};
        run_layer("basic", x, 0);
        for (int k = 0; k < NN; k++)
            check($sformatf("basic_slot%0d", k), 128'(res_y_flat[k*OW +: OW]), 128'(basic_y[k]));

        // Random tables, inputs and neuron latencies
        for (int it = 0; it < 3; it++) begin
            load_random_table();
            lat_cfg = $urandom_range(1, 4);
            run_layer($sformatf("rand%0d", it), rand_x(), 0);
        end

        // Backpressure
        stall_cfg = 5; lat_cfg = 2;
        load_random_table();
        run_layer("bp", rand_x(), 0);

        // Spurious pulse in IDLE
        rv0 = rv_count;
        spur_idle_req = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("spur_idle_y", 128'(res_y_flat), 128'(prev_y));
        check("spur_idle_ready", 128'(req_ready), 128'(1));
        check("spur_idle_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        check("spur_idle_no_res", 128'(rv_count), 128'(rv0));

        // Spurious pulse in ISSUE
        run_layer("spur_issue", rand_x(), 4);

        // Config rules: write while busy, then out-of-range writes in IDLE
        stall_cfg = 0; lat_cfg = 1;
        run_layer("cfg_busy", rand_x(), 1);
        cfg_write(7, rand_row(), rand_bias());
        cfg_write(5, rand_row(), rand_bias());
        x = rand_x();
        run_layer("cfg_after", x, 0);
        check("cfg_slot1_old_row", 128'(res_y_flat[OW +: OW]), 128'(neuron_ref(x, ref_w[1], ref_b[1])));

        // Same-cycle write and request
        run_layer("same_cycle", rand_x(), 2);
        check("same_cycle_slot0", 128'(res_y_flat[0 +: OW]), 128'(16'h0300));

        // Reset while waiting on neuron 2
        lat_cfg = 6;
        rv0 = rv_count;
        run_layer("abort", rand_x(), 3);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_res", 128'(rv_count), 128'(rv0));
        lat_cfg = 2;
        load_random_table();
        run_layer("after_abort", rand_x(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
